serial_sub_ctrl: RTL
====================

Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller. It computes A - B - Bin over WIDTH bits by sequencing one instance of the team's full_sub cell, one bit per clock, LSB first.
- Borrow is carried between bits in a flop. Operand bits are fed from shift registers.
- Start/busy/done handshake lets a host issue subtractions back to back.
- Trades area for latency wherever a ripple-subtractor array is too large.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- CW, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high; clears all state.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; diff and bout are valid from this cycle.
- diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH; registered.
- bout  output  1  final borrow-out; registered.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, bout = 0; diff = 0; shift registers, borrow flop and counter = 0.
- full_sub instance: connected (D, B, X, Y, Z) with X = a_sh[0], Y = b_sh[0], Z = borrow_q.
  - D = X^Y^Z.
  - B = (~X&Y) | (~(X^Y)&Z).
- States:
  - IDLE: busy=0, done=0. On start=1: a_sh<=a, b_sh<=b, borrow_q<=bin, cnt<=0, go RUN.
  - RUN: busy=1. Each edge:
    - d_sh <= {D, d_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; borrow_q <= B; cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1: diff <= {D, d_sh[WIDTH-1:1]}, bout <= B, done <= 1, go DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1: behaves as IDLE+start (capture, go RUN); done drops next cycle.
    - Otherwise go IDLE.
- Latency: start sampled at edge E0 -> busy high after E0 -> done high after edge E_WIDTH. That is WIDTH cycles from the accepting edge, with a throughput of one op per WIDTH+1 cycles.
- diff and bout hold their last result until the next completion. They do not change during RUN.
- start while RUN: ignored. No queuing, no error flag. Inputs a, b, bin may change freely after the accepting edge.
- WIDTH=1: RUN lasts one edge; this reduces to a registered full subtractor.
- Reset mid-RUN: operation is aborted; outputs return to reset values immediately; no done pulse is issued.
- Arithmetic: bout=1 iff a < b + bin as unsigned integers, e.g. 0 - 0 - 1 gives diff=all ones, bout=1.

Test Plan:
1. WIDTH=8, a=8'h5A, b=8'h3C, bin=0, single start pulse -> busy high 8 cycles; done pulse after 8th edge; diff=8'h1E, bout=0.
2. WIDTH=8, a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'h80, b=8'h80, bin=1 -> diff=8'hFF, bout=1.
3. WIDTH=1, all 8 combinations of (a,b,bin) -> (diff,bout) = 00,11,11,01,10,00,00,11 for abc=000..111.
4. WIDTH=8, start=1 held through RUN with a/b changing each cycle -> result uses only the values at the accepting edge; exactly one done pulse before DONE.
5. WIDTH=8, start reasserted in the DONE cycle with a=8'h10, b=8'h01 -> new RUN begins with no IDLE gap; second done after 8 more edges; diff=8'h0F, bout=0.
6. WIDTH=8, rst pulsed (asynchronously, mid-cycle) at bit 4 of an operation -> busy, done, diff, bout = 0 immediately; no done pulse; the next start completes correctly.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin over WIDTH bits, one bit per
// clock, LSB first, using a single full_sub cell and a borrow flop.
// A start/busy/done handshake allows back-to-back operations. A start seen
// in the DONE cycle launches the next operation without an IDLE gap.

module full_sub (
    output logic D,
    output logic B,
    input  logic X,
    input  logic Y,
    input  logic Z
);
    assign D = X ^ Y ^ Z;
    assign B = (~X & Y) | (~(X ^ Y) & Z);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_next;
    logic             borrow_q;
    logic [CW-1:0]    cnt;

    logic             bit_d;
    logic             bit_b;

    logic             capture;
    logic             step;
    logic             finish;

    // Single subtractor cell, reused for every bit position.
    full_sub u_full_sub (
        .D (bit_d),
        .B (bit_b),
        .X (a_sh[0]),
        .Y (b_sh[0]),
        .Z (borrow_q)
    );

    // Result bits enter at the MSB, so after WIDTH steps bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_d_one
            assign d_next = bit_d;
        end else begin : g_d_multi
            assign d_next = {bit_d, d_sh[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and control strobes for the datapath.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST_BIT) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    capture    = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shifters, borrow flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            d_sh     <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (capture) begin
            a_sh     <= a;
            b_sh     <= b;
            borrow_q <= bin;
            cnt      <= '0;
        end else if (step) begin
            a_sh     <= a_sh >> 1;
            b_sh     <= b_sh >> 1;
            d_sh     <= d_next;
            borrow_q <= bit_b;
            cnt      <= cnt + CW'(1);
        end
    end

    // Result registers: updated only on the final bit, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (finish) begin
            diff <= d_next;
            bout <= bit_b;
        end
    end

endmodule
